// File: rtl/qam16_demap.sv
// Hard-decision 16QAM demapper with decision FIFO and serial bit output.
// Optional index-sequence checker: define QAM16_DEMAP_IDX_CHK_EN.
module qam16_demap #(
    parameter int               WIDTH      = 16,
    parameter int               FIFO_DEPTH = 8,
    parameter logic [WIDTH-1:0] THR        = 16'h287A,
    parameter int               LAST_INDEX = 47
) (
    input  logic             qam_clk,
    input  logic             qam_rst,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [5:0]       din_index,
    input  logic [WIDTH-1:0] din_real,
    input  logic [WIDTH-1:0] din_imag,
    output logic             dout,
    output logic             dout_valid,
    output logic [5:0]       dout_index,
    output logic             dout_last,
    output logic             idx_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [WIDTH-1:0] THR_P = $signed(THR);
    localparam logic signed [WIDTH-1:0] THR_N = -$signed(THR);
    localparam logic [5:0] LAST = 6'(LAST_INDEX);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_n;
    logic          ready_q;
    logic          push, pop, empty;
    logic [3:0]    dec;

    state_t     state, state_n;
    logic [1:0] cnt, cnt_n;
    logic [3:0] sh, sh_n;
    logic [5:0] idx, idx_n;
    logic       dout_n, valid_n, last_n;
    logic [5:0] index_n;

    logic signed [WIDTH-1:0] re_s, im_s;
    assign re_s = $signed(din_real);
    assign im_s = $signed(din_imag);

    // Signed window compares avoid abs(), so the most negative code is safe
    assign dec[0] = !din_real[WIDTH-1];
    assign dec[1] = (re_s > THR_N) && (re_s < THR_P);
    assign dec[2] = !din_imag[WIDTH-1];
    assign dec[3] = (im_s > THR_N) && (im_s < THR_P);

    assign din_ready = ready_q;
    assign push      = din_valid && ready_q;
    assign empty     = (count == '0);

    always_comb begin
        count_n = count;
        if (push && !pop)      count_n = count + CW'(1);
        else if (pop && !push) count_n = count - CW'(1);
    end

    always_ff @(posedge qam_clk) begin
        if (qam_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_n;
            ready_q <= (count_n != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge qam_clk) begin
        if (push) mem[wr_ptr] <= {din_index, dec};
    end

    always_ff @(posedge qam_clk) begin
        if (qam_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sh         <= '0;
            idx        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_index <= '0;
            dout_last  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sh         <= sh_n;
            idx        <= idx_n;
            dout       <= dout_n;
            dout_valid <= valid_n;
            dout_index <= index_n;
            dout_last  <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        idx_n   = idx;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    {idx_n, sh_n} = mem[rd_ptr];
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                cnt_n = cnt + 2'd1;
                sh_n  = {1'b0, sh[3:1]};
                if (cnt == 2'd3) begin
                    if (!empty) begin
                        pop   = 1'b1;
                        {idx_n, sh_n} = mem[rd_ptr];
                        cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered one cycle behind the shift register
    always_comb begin
        dout_n  = dout;
        valid_n = 1'b0;
        index_n = dout_index;
        last_n  = 1'b0;
        if (state == SHIFT) begin
            dout_n  = sh[0];
            valid_n = 1'b1;
            index_n = idx;
            last_n  = (cnt == 2'd3) && (idx == LAST);
        end
    end

`ifdef QAM16_DEMAP_IDX_CHK_EN
    logic [5:0] exp_idx;
    logic       err_q;

    always_ff @(posedge qam_clk) begin
        if (qam_rst) begin
            exp_idx <= '0;
            err_q   <= 1'b0;
        end else if (push) begin
            if (din_index != exp_idx) err_q <= 1'b1;
            exp_idx <= (din_index == LAST) ? 6'd0 : din_index + 6'd1;
        end
    end

    assign idx_err = err_q;
`else
    assign idx_err = 1'b0;
`endif

endmodule

// File: tb/tb_qam16_demap.sv
// Directed bench for qam16_demap with a bit-level scoreboard.
// Expected idx_err follows QAM16_DEMAP_IDX_CHK_EN.
module tb_qam16_demap;

    logic        qam_clk = 1'b0;
    logic        qam_rst = 1'b1;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [5:0]  din_index = '0;
    logic [15:0] din_real = '0;
    logic [15:0] din_imag = '0;
    logic        dout, dout_valid, dout_last, idx_err;
    logic [5:0]  dout_index;

    qam16_demap dut (
        .qam_clk(qam_clk), .qam_rst(qam_rst),
        .din_valid(din_valid), .din_ready(din_ready),
        .din_index(din_index), .din_real(din_real), .din_imag(din_imag),
        .dout(dout), .dout_valid(dout_valid), .dout_index(dout_index),
        .dout_last(dout_last), .idx_err(idx_err)
    );

    always #5 qam_clk = ~qam_clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];
    logic mon_en = 0, no_bubble = 0, prev_valid = 0, stalled = 0;
    logic exp_err = 0, lat_arm = 0;
    int lat_cnt = 0, frame_bits = 0, last_cnt = 0, last_pos = 0;

    logic [15:0] lvl [4] = '{16'hC349, 16'hEBC3, 16'h143D, 16'h3CB7};
    logic        c0 [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        c1 [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [5:0] idx, input logic [15:0] re,
                        input logic [15:0] im, input logic [3:0] bits);
        int w = 0;
        @(negedge qam_clk);
        din_valid = 1'b1;
        din_index = idx;
        din_real  = re;
        din_imag  = im;
        while (din_ready !== 1'b1 && w < 200) begin
            stalled = 1'b1;
            @(negedge qam_clk);
            w++;
        end
        if (w >= 200) chk("accept_timeout", din_ready, 1);
        @(posedge qam_clk);
        for (int b = 0; b < 4; b++)
            sb.push_back({(b == 3) && (idx == 6'd47), idx, bits[b]});
    endtask

    task automatic idle();
        @(negedge qam_clk);
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((sb.size() != 0 || dout_valid !== 1'b0) && w < 600) begin
            @(posedge qam_clk);
            #1;
            w++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic send_lvl(input logic [5:0] idx, input int i, input int j);
        send(idx, lvl[i], lvl[j], {c1[j], c0[j], c1[i], c0[i]});
    endtask

    always begin
        logic [7:0] it;
        @(posedge qam_clk);
        #1;
        if (mon_en) begin
            chk("idx_err", idx_err, exp_err);
            if (dout_valid !== 1'b1) begin
                if (lat_arm) lat_cnt++;
                chk("last_idle", dout_last, 0);
                if (no_bubble && prev_valid && sb.size() != 0)
                    chk("bubble", dout_valid, 1);
            end else if (sb.size() == 0) begin
                chk("spurious_valid", dout_valid, 0);
            end else begin
                it = sb.pop_front();
                chk("dout", dout, it[0]);
                chk("dout_index", dout_index, it[6:1]);
                chk("dout_last", dout_last, it[7]);
                if (lat_arm) begin
                    chk("latency", lat_cnt, 2);
                    lat_arm = 0;
                end
                frame_bits++;
                if (dout_last === 1'b1) begin
                    last_cnt++;
                    last_pos = frame_bits;
                end
            end
            prev_valid = (dout_valid === 1'b1);
        end
    end

    initial begin
        repeat (3) @(posedge qam_clk);
        #1;
        chk("rst_ready", din_ready, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_index", dout_index, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_idx_err", idx_err, 0);
        @(negedge qam_clk);
        qam_rst = 1'b0;
        @(posedge qam_clk);
        #1;
        chk("ready_after_rst", din_ready, 1);
        mon_en = 1;

        // Corner points with latency check on the first
        send(6'd0, 16'h3CB7, 16'hC349, 4'b0001);
        lat_arm = 1;
        lat_cnt = 0;
        idle();
        drain();
        chk("latency_seen", lat_arm, 0);
        send(6'd1, 16'h143D, 16'hEBC3, 4'b1011);
        idle();
        drain();
        chk("hold_index", dout_index, 1);
        chk("hold_dout", dout, 1);
        send(6'd2, 16'hC349, 16'hEBC3, 4'b1000);
        idle();
        drain();

        // Decision thresholds on the real axis
        send(6'd3, 16'h287A, 16'h3CB7, 4'b0101);
        send(6'd4, 16'h2879, 16'h3CB7, 4'b0111);
        send(6'd5, 16'h0000, 16'h3CB7, 4'b0111);
        send(6'd6, 16'hD786, 16'h3CB7, 4'b0100);
        send(6'd7, 16'hD787, 16'h3CB7, 4'b0110);
        send(6'd8, 16'h8000, 16'h3CB7, 4'b0100);
        idle();
        drain();

        // Back-to-back burst overruns the FIFO
        no_bubble = 1;
        stalled = 0;
        for (int k = 0; k < 12; k++)
            send_lvl(6'(9 + k), k % 4, (k / 4 + k) % 4);
        idle();
        chk("burst_stalled", stalled, 1);
        drain();
        no_bubble = 0;

        @(negedge qam_clk);
        qam_rst = 1'b1;
        exp_err = 0;
        @(negedge qam_clk);
        qam_rst = 1'b0;

        // Full frame: a single last marker on bit 192
        frame_bits = 0;
        last_cnt = 0;
        for (int k = 0; k < 48; k++)
            send_lvl(6'(k), (k * 3) % 4, (k + 1) % 4);
        send_lvl(6'd0, 2, 1);
        idle();
        drain();
        chk("last_count", last_cnt, 1);
        chk("last_pos", last_pos, 192);

        // Reset while symbols are buffered
        for (int k = 1; k <= 10; k++)
            send_lvl(6'(k), k % 4, 3 - (k % 4));
        idle();
        repeat (6) @(posedge qam_clk);
        @(negedge qam_clk);
        qam_rst = 1'b1;
        sb.delete();
        exp_err = 0;
        @(posedge qam_clk);
        #1;
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_ready", din_ready, 0);
        @(negedge qam_clk);
        qam_rst = 1'b0;
        @(posedge qam_clk);
        #1;
        chk("midrst_ready_after", din_ready, 1);
        repeat (20) @(posedge qam_clk);

        // Index sequence 0..5 then 7
        for (int k = 0; k < 6; k++)
            send_lvl(6'(k), k % 4, k % 4);
        send_lvl(6'd7, 1, 2);
`ifdef QAM16_DEMAP_IDX_CHK_EN
        exp_err = 1;
`endif
        send_lvl(6'd8, 0, 3);
        send_lvl(6'd9, 3, 0);
        idle();
        drain();
        chk("idx_err_final", idx_err, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
